serial_word_feeder: RTL
=======================

Name: serial_word_feeder

Overview:
- Parallel-in, serial-out stage that sits directly upstream of the bit-serial mod-3 divisibility FSM.
- Accepts a WIDTH-bit word through a valid/ready handshake and streams it MSB-first, one bit per clock.
- Marks the first and last bit of each word so the downstream FSM can clear at frame start and sample its verdict at frame end.
- Supports back-to-back words with no bubble cycles.

Parameters:
- WIDTH, 8, word length in bits; legal range is WIDTH >= 2.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  upstream presents a word on load_data.
- load_data  in  WIDTH  word to serialize; sampled only on a handshake.
- load_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  current serial bit; drives the downstream FSM's bit input.
- ser_valid  out  1  ser_out holds a live bit this cycle.
- frame_start  out  1  high with the first (MSB) bit of a word.
- frame_end  out  1  high with the last (LSB) bit of a word.
- busy  out  1  high while a word is being shifted.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE; shift register and bit counter clear to 0.
  - ser_out, ser_valid, frame_start, frame_end and busy are 0.
  - load_ready is 0 while rst is high, and 1 on the first cycle after release.
- States:
  - IDLE: load_ready=1, ser_valid=0, busy=0.
  - SHIFT: busy=1, ser_valid=1.
- Handshake:
  - A transfer occurs on a rising edge where load_valid and load_ready are both 1.
  - load_data is captured into the internal shift register at that edge.
  - load_valid with load_ready=0 is ignored; upstream must hold the word.
  - Changes on load_data outside a handshake have no effect.
- Latency: the first bit appears in the cycle after the handshake edge: ser_valid=1, ser_out=load_data[WIDTH-1], frame_start=1.
- Shifting:
  - Each following cycle emits the next lower bit; the shift register shifts left and the counter increments.
  - The counter is ceil(log2(WIDTH)) bits wide and runs 0..WIDTH-1.
  - Cycle k of the word (k=0..WIDTH-1) outputs data[WIDTH-1-k].
  - frame_start is 1 only at k=0; frame_end is 1 only at k=WIDTH-1.
  - All outputs except load_ready are registered.
- End of word:
  - On the k=WIDTH-1 cycle, load_ready=1 (default build).
  - If a handshake occurs on that edge, the next cycle is k=0 of the new word: frame_start=1, ser_valid stays 1, no gap.
  - Otherwise the block returns to IDLE; ser_valid=0 and ser_out=0.
- Idle outputs: ser_out is forced to 0 whenever ser_valid=0.
- Reset mid-word: the word is discarded, no frame_end is produced, and the block is in IDLE after release.

Optional Feature:
- Macro: INTERWORD_GAP_EN.
- Defined:
  - load_ready is 1 only in IDLE, never on the k=WIDTH-1 cycle.
  - After every frame_end there is at least one cycle with ser_valid=0, so the downstream stage gets a guaranteed settle/readout slot.
  - Minimum word period is WIDTH+1 cycles.
- Undefined: back-to-back operation as in Behaviour; minimum word period is WIDTH cycles.

Test Plan:
- Reset then single word: rst=1 for 10 cycles, release, load 8'hB4 ->
  - load_ready=1 after release.
  - ser_out sequence 1,0,1,1,0,1,0,0 over 8 cycles with ser_valid=1 throughout.
  - frame_start on cycle 1 only, frame_end on cycle 8 only, then ser_valid=0 and busy=0.
- Back-to-back, macro undefined: 8'h96 then 8'h07 with load_valid held high ->
  - 16 consecutive valid bits 10010110 00000111.
  - frame_end on bit 8 and frame_start on bit 9, with no bubble.
- Back-to-back, INTERWORD_GAP_EN defined: same stimulus ->
  - Exactly one cycle with ser_valid=0 between the two words.
  - load_ready=0 on the bit-8 cycle.
- Backpressure: assert load_valid with 8'hFF while busy, then change load_data to 8'h00 mid-word ->
  - No capture during the word.
  - 8'h00 is taken only at the first legal ready edge and serialized as eight zeros.
- Async reset mid-word: load 8'hAA, assert rst asynchronously after 3 bits ->
  - Outputs go to 0 without waiting for a clock edge.
  - No frame_end is produced.
  - After release a new word 8'h03 serializes cleanly as 00000011.
- Downstream check: feed 8'h96 (150) then 8'h97 (151) into the mod-3 detector, clearing it on frame_start ->
  - Divisible flag is 1 at the frame_end of 8'h96.
  - Divisible flag is 0 at the frame_end of 8'h97.

Source files
------------

// File: rtl/serial_word_feeder.sv
// rtl/serial_word_feeder.sv - parallel-in, MSB-first serial-out word feeder for a bit-serial mod-3 FSM
//
// Optional build macro: INTERWORD_GAP_EN
//   undefined : back-to-back words, load_ready also high on the last bit of a word
//   defined   : load_ready only in IDLE, forcing one ser_valid=0 cycle after every frame_end

module serial_word_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             frame_start_o,
  output logic             frame_end_o,
  output logic             busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             ser_valid_q;
  logic             frame_start_q;
  logic             frame_end_q;
  logic             busy_q;
  logic             last_bit;
  logic             ready;
  logic             take;

  // The MSB of the shift register is the live serial bit; it is cleared in IDLE so ser_out reads 0 there.
  assign ser_out_o     = shreg_q[WIDTH-1];
  assign ser_valid_o   = ser_valid_q;
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign busy_o        = busy_q;

  // Next shift-register contents and bit counter while a word is streaming.
  always_comb begin
    shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
    cnt_d    = cnt_q + CW'(1);
    last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`ifdef INTERWORD_GAP_EN
    ready    = (state_q == IDLE);
`else
    ready    = (state_q == IDLE) || last_bit;
`endif
  end

  // load_ready is the only combinational output; it is held low while reset is asserted.
  assign load_ready_o = ready && !rst_i;
  assign take         = load_valid_i && load_ready_o;

  // Control FSM with registered serial outputs; a handshake always starts a fresh word at k=0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      if (take) begin
        state_q       <= SHIFT;
        shreg_q       <= load_data_i;
        cnt_q         <= '0;
        ser_valid_q   <= 1'b1;
        busy_q        <= 1'b1;
        frame_start_q <= 1'b1;
      end else if ((state_q == SHIFT) && !last_bit) begin
        shreg_q       <= shreg_d;
        cnt_q         <= cnt_d;
        frame_end_q   <= (cnt_d == LAST_CNT);
      end else if (last_bit) begin
        state_q       <= IDLE;
        shreg_q       <= '0;
        cnt_q         <= '0;
        ser_valid_q   <= 1'b0;
        busy_q        <= 1'b0;
      end
    end
  end

endmodule
